csr_exec_unit: RTL and testbench
================================

Name: csr_exec_unit

Overview:
- Execute-stage sequencer for Zicsr instructions (CSRRW/CSRRS/CSRRC and the immediate forms).
- Accepts one CSR op from the pipeline over a valid/ready handshake.
- Reads the old value from the CSR file, computes the new value, and issues a single-cycle write to the CSR file's write port. It then returns the old value for rd writeback.
- Sits directly upstream of csr_file: it drives csr_file's write, wrAddr, wrVal and rdAddr ports and consumes its rdVal.

Parameters:
- XLEN, 32, data width of CSRs and operands.
- CSR_AW, 12, CSR address width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CSR op presented.
- req_ready  out  1  unit idle and able to accept; high only in IDLE.
- req_funct3  in  3  instruction funct3.
- req_csr_addr  in  CSR_AW  target CSR.
- req_rs1_val  in  XLEN  rs1 register value (register forms).
- req_zimm  in  5  rs1 field / zero-extended immediate.
- resp_valid  out  1  result available.
- resp_ready  in  1  pipeline consumes the result.
- resp_rdata  out  XLEN  old CSR value for rd.
- resp_illegal  out  1  illegal-instruction flag accompanying the response.
- csr_write  out  1  write strobe to csr_file.
- csr_wr_addr  out  CSR_AW  write address.
- csr_wr_val  out  XLEN  write data.
- csr_rd_addr  out  CSR_AW  read address.
- csr_rd_val  in  XLEN  combinational read data from csr_file.
- instret_inc  in  1  one instruction retired this cycle (used only with the optional feature).

Behaviour:
- Reset values: req_ready=0 during reset then 1; resp_valid=0, resp_rdata=0, resp_illegal=0, csr_write=0, csr_wr_addr=0, csr_wr_val=0, csr_rd_addr=0. FSM enters IDLE.
- States and transitions:
  - IDLE: req_ready=1. Handshake (req_valid & req_ready) latches all req_* fields and goes to RD.
  - RD: csr_rd_addr = latched addr. csr_rd_val is registered as old value. Go to WR.
  - WR: compute operand and new value. csr_write is high for exactly this cycle if a write is required. Go to RSP.
  - RSP: resp_valid=1, held with stable resp_rdata/resp_illegal until resp_ready=1. Return to IDLE on the cycle after the handshake.
- Minimum latency: accept at cycle 0, write at cycle 2, resp_valid at cycle 3. The next request can be accepted one cycle after the response handshake.
- Operand: funct3[2]=1 uses {27'b0, zimm}; otherwise uses rs1_val.
- New value:
  - RW (x01): operand.
  - RS (x10): old | operand.
  - RC (x11): old & ~operand.
- Write suppression: RS/RC with zimm==0 (rs1=x0 or immediate 0) perform no write. RW always writes.
- Illegal when either holds:
  - funct3 is 000 or 100;
  - addr[11:10]==2'b11 (read-only) and a write would occur.
- On an illegal op: no write, resp_rdata=0, resp_illegal=1.
- csr_rd_addr holds its last value outside RD. csr_write is never high outside WR.
- Reset asserted in any state: next cycle is IDLE, any pending write is dropped (csr_write=0 that cycle), and the response is discarded.
- req_valid while not in IDLE is ignored (req_ready=0).

Optional Feature:
- CSR_COUNTERS_EN defined: local 64-bit cycle and instret counters.
  - cycle increments every non-reset cycle; instret increments when instret_inc=1. Both wrap 2^64-1 -> 0 and are cleared by reset.
  - Reads of 0xC00/0xC80/0xB00/0xB80 (cycle lo/hi) and 0xC02/0xC82/0xB02/0xB82 (instret lo/hi) return the counter halves, not csr_rd_val.
  - Writes to 0xB00/0xB80/0xB02/0xB82 replace the addressed 32-bit half. Counter writes are still mirrored to csr_file. The counter increment in the write cycle is suppressed for the written counter.
- CSR_COUNTERS_EN undefined: no counter state. All addresses are served by csr_file, and instret_inc is ignored.

Decomposition:
- csr_pkg holds:
  - funct3 encodings (CSRRW=3'b001, CSRRS=3'b010, CSRRC=3'b011, immediate forms 101/110/111);
  - FSM state encoding (IDLE, RD, WR, RSP);
  - counter CSR address constants;
  - the read-only address predicate.
- One sub-module, csr_counter64: 64-bit counter with increment enable and per-half write, instantiated twice under CSR_COUNTERS_EN.

Test Plan:
- csr_file[0x300]=0x0000_0008; CSRRS 0x300 rs1_val=0x0000_0080 -> rdata=0x08, write 0x88 in cycle 2, resp_valid in cycle 3.
- CSRRCI 0x300 zimm=0 with value 0x88 -> no csr_write pulse, rdata=0x88, illegal=0.
- CSRRW 0xC00 rs1_val=1 -> illegal=1, rdata=0, no write. CSRRS 0xC00 zimm=0 -> legal read.
- funct3=100 -> illegal=1. Hold resp_ready=0 for 5 cycles -> resp_valid, rdata and illegal stay stable and req_ready=0 throughout.
- Assert reset during WR -> csr_write=0 that cycle, resp_valid never rises, req_ready=1 the cycle after reset deasserts.
- With CSR_COUNTERS_EN: write 0xB00=0xFFFF_FFFF and 0xB80=0xFFFF_FFFF, wait 2 cycles -> 0xC00 read reflects wrap through 0. instret_inc pulsed 3 times -> 0xC02 reads 3.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the Zicsr execute sequencer: funct3 encodings, FSM states,
// counter CSR addresses and address-class helpers.
package csr_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } csr_state_e;

  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef struct packed {
    logic hit;
    logic instret;
    logic hi;
  } csr_ctr_sel_t;

  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

  // User-mode aliases (0xCxx) and machine-mode aliases (0xBxx) map onto the same counters.
  function automatic csr_ctr_sel_t csr_counter_decode(input logic [11:0] addr);
    csr_ctr_sel_t s;
    s = '0;
    case (addr)
      CSR_CYCLE,    CSR_MCYCLE:    begin s.hit = 1'b1; end
      CSR_CYCLEH,   CSR_MCYCLEH:   begin s.hit = 1'b1; s.hi = 1'b1; end
      CSR_INSTRET,  CSR_MINSTRET:  begin s.hit = 1'b1; s.instret = 1'b1; end
      CSR_INSTRETH, CSR_MINSTRETH: begin s.hit = 1'b1; s.instret = 1'b1; s.hi = 1'b1; end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/csr_exec_unit_counter64.sv
// 64-bit free-running counter with increment enable and per-half overwrite;
// a write in a cycle replaces the increment for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wr_data,
  output logic [63:0] o_value
);

  logic [63:0] r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
    end else if (i_wr_lo) begin
      r_value[31:0] <= i_wr_data;
    end else if (i_wr_hi) begin
      r_value[63:32] <= i_wr_data;
    end else if (i_inc) begin
      r_value <= r_value + 64'd1;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/csr_exec_unit.sv
// Execute-stage sequencer for Zicsr ops: IDLE -> RD -> WR -> RSP around an external csr_file.
// Define CSR_COUNTERS_EN to add local 64-bit cycle/instret counters.
module csr_exec_unit
  import csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [CSR_AW-1:0] req_csr_addr,
  input  logic [XLEN-1:0]   req_rs1_val,
  input  logic [4:0]        req_zimm,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_illegal,
  output logic              csr_write,
  output logic [CSR_AW-1:0] csr_wr_addr,
  output logic [XLEN-1:0]   csr_wr_val,
  output logic [CSR_AW-1:0] csr_rd_addr,
  input  logic [XLEN-1:0]   csr_rd_val,
  input  logic              instret_inc
);

  csr_state_e        r_state;
  csr_state_e        w_next;
  logic [2:0]        r_funct3;
  logic [CSR_AW-1:0] r_addr;
  logic [XLEN-1:0]   r_rs1;
  logic [4:0]        r_zimm;
  logic              r_do_write;
  logic [CSR_AW-1:0] r_wr_addr;
  logic [XLEN-1:0]   r_wr_val;
  logic [XLEN-1:0]   r_resp_rdata;
  logic              r_resp_illegal;

  logic              w_req_ready;
  logic              w_resp_valid;
  logic              w_csr_write;
  logic              w_accept;
  logic [XLEN-1:0]   w_old;
  logic [XLEN-1:0]   w_operand;
  logic [XLEN-1:0]   w_new;
  logic              w_f3_valid;
  logic              w_wants_write;
  logic              w_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Reset gates the strobes combinationally so a write in flight is dropped that same cycle.
  always_comb begin
    w_next       = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_csr_write  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = !reset;
        if (req_valid) w_next = ST_RD;
      end
      ST_RD: w_next = ST_WR;
      ST_WR: begin
        w_csr_write = r_do_write & !reset;
        w_next      = ST_RSP;
      end
      ST_RSP: begin
        w_resp_valid = !reset;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept = req_valid & w_req_ready;

  assign w_operand     = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_zimm} : r_rs1;
  assign w_f3_valid    = (r_funct3[1:0] != 2'b00);
  // The rs1 field doubles as zimm, so a zero field suppresses set/clear writes in both forms.
  assign w_wants_write = (r_funct3[1:0] == 2'b01) | (r_zimm != 5'd0);
  assign w_illegal     = !w_f3_valid | (csr_is_read_only(r_addr[11:0]) & w_wants_write);

  always_comb begin
    w_new = w_operand;
    case (r_funct3)
      F3_CSRRW, F3_CSRRWI: w_new = w_operand;
      F3_CSRRS, F3_CSRRSI: w_new = w_old | w_operand;
      F3_CSRRC, F3_CSRRCI: w_new = w_old & ~w_operand;
      default:             w_new = w_operand;
    endcase
  end

  // The old value is captured in RD; write data and response fields are staged there too.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_funct3       <= '0;
      r_addr         <= '0;
      r_rs1          <= '0;
      r_zimm         <= '0;
      r_do_write     <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_val       <= '0;
      r_resp_rdata   <= '0;
      r_resp_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funct3 <= req_funct3;
        r_addr   <= req_csr_addr;
        r_rs1    <= req_rs1_val;
        r_zimm   <= req_zimm;
      end
      if (r_state == ST_RD) begin
        r_do_write     <= w_wants_write & !w_illegal;
        r_resp_rdata   <= w_illegal ? '0 : w_old;
        r_resp_illegal <= w_illegal;
        if (w_wants_write & !w_illegal) begin
          r_wr_addr <= r_addr;
          r_wr_val  <= w_new;
        end
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_ctr_sel_t w_rd_sel;
  csr_ctr_sel_t w_wr_sel;
  logic [63:0]  w_cycle;
  logic [63:0]  w_instret;
  logic [63:0]  w_ctr_val;
  logic [31:0]  w_ctr_half;

  assign w_rd_sel   = csr_counter_decode(r_addr[11:0]);
  assign w_wr_sel   = csr_counter_decode(r_wr_addr[11:0]);
  assign w_ctr_val  = w_rd_sel.instret ? w_instret : w_cycle;
  assign w_ctr_half = w_rd_sel.hi ? w_ctr_val[63:32] : w_ctr_val[31:0];
  assign w_old      = w_rd_sel.hit ? w_ctr_half : csr_rd_val;

  csr_counter64 u_cycle (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (1'b1),
    .i_wr_lo   (w_csr_write & w_wr_sel.hit & !w_wr_sel.instret & !w_wr_sel.hi),
    .i_wr_hi   (w_csr_write & w_wr_sel.hit & !w_wr_sel.instret &  w_wr_sel.hi),
    .i_wr_data (r_wr_val[31:0]),
    .o_value   (w_cycle)
  );

  csr_counter64 u_instret (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (instret_inc),
    .i_wr_lo   (w_csr_write & w_wr_sel.hit &  w_wr_sel.instret & !w_wr_sel.hi),
    .i_wr_hi   (w_csr_write & w_wr_sel.hit &  w_wr_sel.instret &  w_wr_sel.hi),
    .i_wr_data (r_wr_val[31:0]),
    .o_value   (w_instret)
  );
`else
  logic w_unused_instret;
  assign w_unused_instret = instret_inc;
  assign w_old            = csr_rd_val;
`endif

  assign req_ready    = w_req_ready;
  assign resp_valid   = w_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_illegal = r_resp_illegal;
  assign csr_write    = w_csr_write;
  assign csr_wr_addr  = r_wr_addr;
  assign csr_wr_val   = r_wr_val;
  assign csr_rd_addr  = r_addr;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Self-checking bench for csr_exec_unit: directed Zicsr scenarios plus random ops
// checked against an instruction-level reference model and a csr_file shadow.
module tb_csr_exec_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_zimm;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_illegal;
  logic        csr_write;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_val;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_val;
  logic        instret_inc;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem    [4096];
  logic [31:0] shadow [4096];
  logic        init_mem;

  csr_exec_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_csr_addr (req_csr_addr),
    .req_rs1_val  (req_rs1_val),
    .req_zimm     (req_zimm),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_illegal (resp_illegal),
    .csr_write    (csr_write),
    .csr_wr_addr  (csr_wr_addr),
    .csr_wr_val   (csr_wr_val),
    .csr_rd_addr  (csr_rd_addr),
    .csr_rd_val   (csr_rd_val),
    .instret_inc  (instret_inc)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] seed_val(input int a);
    if (a == 32'h300) return 32'h0000_0008;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // csr_file model: combinational read, single write port
  assign csr_rd_val = mem[csr_rd_addr];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= seed_val(i);
    end else if (csr_write) begin
      mem[csr_wr_addr] <= csr_wr_val;
    end
  end

  // Instruction-level reference: what the op returns and what it leaves in the CSR.
  function automatic void ref_model(input logic [2:0] f3, input logic [11:0] addr,
                                    input logic [31:0] old, input logic [31:0] rs1,
                                    input logic [4:0] zimm, output logic [31:0] rdata,
                                    output bit ill, output bit wr, output logic [31:0] nv);
    logic [31:0] opnd;
    bit          bad_f3;
    opnd   = (f3 >= 3'd4) ? {27'd0, zimm} : rs1;
    bad_f3 = 1'b0;
    wr     = 1'b0;
    nv     = old;
    case (f3)
      3'd1, 3'd5: begin nv = opnd;         wr = 1'b1;         end
      3'd2, 3'd6: begin nv = old | opnd;   wr = (zimm != 0);  end
      3'd3, 3'd7: begin nv = old & ~opnd;  wr = (zimm != 0);  end
      default:    bad_f3 = 1'b1;
    endcase
    ill = bad_f3 || (addr >= 12'hC00 && wr);
    if (ill) wr = 1'b0;
    rdata = ill ? 32'd0 : old;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: issue one op, follow it to the response, hold resp_ready low for `hold` cycles.
  task automatic do_op(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                       input logic [4:0] zimm, input int hold, input bit chk_rdata,
                       output logic [31:0] got_rdata);
    logic [31:0] e_rdata, e_val, wr_val_s;
    logic [11:0] wr_addr_s;
    bit          e_ill, e_wr, busy_ready;
    int          n, off, wr_cnt, wr_off, resp_off;
    ref_model(f3, addr, shadow[addr], rs1, zimm, e_rdata, e_ill, e_wr, e_val);
    @(negedge clk);
    req_funct3   = f3;
    req_csr_addr = addr;
    req_rs1_val  = rs1;
    req_zimm     = zimm;
    req_valid    = 1'b1;
    resp_ready   = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid    = 1'b0;
    req_funct3   = 3'($urandom);
    req_csr_addr = 12'($urandom);
    req_rs1_val  = $urandom;
    req_zimm     = 5'($urandom);
    off = 1; wr_cnt = 0; wr_off = 0; resp_off = 0; busy_ready = 1'b0;
    wr_val_s = '0; wr_addr_s = '0;
    while (off <= 20 && resp_off == 0) begin
      if (req_ready) busy_ready = 1'b1;
      if (csr_write) begin
        wr_cnt++; wr_off = off; wr_val_s = csr_wr_val; wr_addr_s = csr_wr_addr;
      end
      if (resp_valid) resp_off = off;
      else begin @(negedge clk); off++; end
    end
    check("resp_latency", resp_off, 3);
    check("busy_req_ready", busy_ready, 0);
    check("write_count", wr_cnt, e_wr ? 1 : 0);
    if (e_wr) begin
      check("write_cycle", wr_off, 2);
      check("write_addr", wr_addr_s, addr);
      check("write_val", wr_val_s, e_val);
    end
    check("resp_illegal", resp_illegal, e_ill);
    if (chk_rdata) check("resp_rdata", resp_rdata, e_rdata);
    got_rdata = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_illegal", resp_illegal, e_ill);
      if (chk_rdata) check("hold_rdata", resp_rdata, e_rdata);
      check("hold_req_ready", req_ready, 0);
      check("hold_no_write", csr_write, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("ready_after_resp", req_ready, 1);
    check("valid_after_resp", resp_valid, 0);
    if (e_wr) shadow[addr] = e_val;
    check("csr_file_value", mem[addr], shadow[addr]);
  endtask

  // Stimulus sequence
  initial begin
    logic [31:0] got;
    int          n, seen_valid, seen_write;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  zimm;
    bit          ctr_build;
`ifdef CSR_COUNTERS_EN
    ctr_build = 1'b1;
`else
    ctr_build = 1'b0;
`endif
    for (int i = 0; i < 4096; i++) shadow[i] = seed_val(i);
    reset = 1'b1; init_mem = 1'b1;
    req_valid = 1'b0; req_funct3 = '0; req_csr_addr = '0; req_rs1_val = '0; req_zimm = '0;
    resp_ready = 1'b0; instret_inc = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 0);
    reset = 1'b0; init_mem = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_illegal", resp_illegal, 0);
    check("rst_csr_write", csr_write, 0);
    check("rst_wr_addr", csr_wr_addr, 0);
    check("rst_wr_val", csr_wr_val, 0);
    check("rst_rd_addr", csr_rd_addr, 0);

    // Directed: set, clear-with-zero, read-only write, read-only read, bad funct3 with stall
    do_op(3'b010, 12'h300, 32'h0000_0080, 5'd5, 0, 1'b1, got);
    check("csrrs_rdata", got, 32'h08);
    check("csrrs_newval", mem[12'h300], 32'h88);
    do_op(3'b111, 12'h300, 32'hFFFF_FFFF, 5'd0, 0, 1'b1, got);
    check("csrrci0_rdata", got, 32'h88);
    do_op(3'b001, 12'hC00, 32'h1, 5'd1, 0, 1'b1, got);
    check("ro_write_rdata", got, 32'h0);
    do_op(3'b010, 12'hC00, 32'h0, 5'd0, 0, !ctr_build, got);
    do_op(3'b100, 12'h300, 32'h1234, 5'd7, 5, 1'b1, got);
    do_op(3'b000, 12'h305, 32'h55, 5'd2, 1, 1'b1, got);

    // Reset while the write is in flight
    @(negedge clk);
    req_funct3 = 3'b001; req_csr_addr = 12'h340; req_rs1_val = 32'hDEAD_BEEF; req_zimm = 5'd9;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_write", csr_write, 1);
    reset = 1'b1;
    #1;
    check("reset_drops_write", csr_write, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_req_ready", req_ready, 1);
    check("post_reset_rdata", resp_rdata, 0);
    seen_valid = 0; seen_write = 0;
    for (int k = 0; k < 6; k++) begin
      if (resp_valid) seen_valid++;
      if (csr_write) seen_write++;
      @(negedge clk);
    end
    check("post_reset_no_valid", seen_valid, 0);
    check("post_reset_no_write", seen_write, 0);
    check("post_reset_csr340", mem[12'h340], shadow[12'h340]);

    // Random ops
    for (int t = 0; t < 40; t++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: addr = 12'h300;
        1: addr = 12'h305;
        2: addr = 12'h340;
        3: addr = 12'hF11;
        4: addr = 12'hD23;
        default: addr = {2'b01, 10'($urandom)};
      endcase
      zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op(f3, addr, $urandom, zimm, $urandom_range(0, 2), 1'b1, got);
    end

`ifdef CSR_COUNTERS_EN
    do_op(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd1, 0, 1'b0, got);
    do_op(3'b001, 12'hB80, 32'hFFFF_FFFF, 5'd1, 0, 1'b0, got);
    repeat (2) @(negedge clk);
    do_op(3'b010, 12'hC00, 32'h0, 5'd0, 0, 1'b0, got);
    check("cycle_lo_wrapped", got < 32'd64, 1);
    do_op(3'b010, 12'hC80, 32'h0, 5'd0, 0, 1'b0, got);
    check("cycle_hi_written", got, 32'hFFFF_FFFF);
    for (int p = 0; p < 3; p++) begin
      @(negedge clk); instret_inc = 1'b1;
      @(negedge clk); instret_inc = 1'b0;
    end
    do_op(3'b010, 12'hC02, 32'h0, 5'd0, 0, 1'b0, got);
    check("instret_count", got, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
